mem_access_unit: RTL and testbench

- Sits directly downstream of the memory pipeline stage, between it and the word-wide data RAM.
- Turns one load/store request (byte, halfword or word, signed or unsigned) into RAM cycles:
  - sub-word stores use read-modify-write on the aligned word;
  - loads extract the addressed lane and extend it to 32 bits.
- Reports completion with a single-cycle pulse, which feeds the memory stage's mem_done path.

---
 rtl/mem_access_unit_if.sv | 37 +++
 rtl/mem_access_unit.sv | 188 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response and RAM bus bundle for mem_access_unit.
//   req_*  : load/store request from the memory stage (valid/ready)
//   resp_* : one-cycle completion pulse with load data and error flag
//   ram_*  : word-wide data RAM port (aligned address, write data/strobe, read data)
// slave modport is the unit; master modport is the requester plus RAM side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] ram_address;
  logic [31:0] ram_data_in;
  logic        ram_write_enable;
  logic [31:0] ram_data_out;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_error,
    output ram_address, ram_data_in, ram_write_enable,
    input  ram_data_out
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_error,
    input  ram_address, ram_data_in, ram_write_enable,
    output ram_data_out
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit between the memory stage and a word-wide data RAM.
// Sub-word stores are done as read-modify-write of the aligned word; loads
// extract the addressed lane and sign/zero-extend it.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : mem_access_unit_if.slave (request, response and RAM signals)
// Parameter RAM_LATENCY: cycles from ram_address to ram_data_out (0..7).
module mem_access_unit #(
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);

  localparam int unsigned DataW = 32;
  localparam int unsigned CntW  = 3;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            stateQ, stateD;
  logic [CntW-1:0]   cntQ, cntD;

  // Captured request
  logic              writeQ;
  logic [1:0]        sizeQ;
  logic              unsignedQ;
  logic [DataW-1:0]  addrQ;
  logic [15:0]       wdataQ;

  // Registered outputs and their next values
  logic              respValidQ, respValidD;
  logic              respErrorQ, respErrorD;
  logic [DataW-1:0]  respRdataQ, respRdataD;
  logic [DataW-1:0]  ramAddrQ, ramAddrD;
  logic [DataW-1:0]  ramDataInQ, ramDataInD;
  logic              ramWeQ, ramWeD;

  logic              accept;
  logic              illegal;

  // Lane extraction with sign/zero extension; word size returns the word as is
  function automatic logic [DataW-1:0] extractLoad(
    input logic [DataW-1:0] word,
    input logic [1:0]       size,
    input logic [1:0]       lane,
    input logic             isUnsigned
  );
    logic [7:0]       b;
    logic [15:0]      h;
    logic [DataW-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = isUnsigned ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = isUnsigned ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the target lane of the old word
  function automatic logic [DataW-1:0] mergeStore(
    input logic [DataW-1:0] word,
    input logic [15:0]      wdata,
    input logic [1:0]       size,
    input logic [1:0]       lane
  );
    logic [DataW-1:0] r;
    r = word;
    if (size == 2'b00) r[{lane, 3'b000} +: 8]     = wdata[7:0];
    else               r[{lane[1], 4'b0000} +: 16] = wdata;
    return r;
  endfunction

  assign accept  = (stateQ == IDLE) && bus.req_valid;
  assign illegal = (bus.req_size == 2'b11)
                || ((bus.req_size == 2'b01) && bus.req_addr[0])
                || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= IDLE;
      cntQ       <= '0;
      respValidQ <= 1'b0;
      respErrorQ <= 1'b0;
      respRdataQ <= '0;
      ramAddrQ   <= '0;
      ramDataInQ <= '0;
      ramWeQ     <= 1'b0;
    end else begin
      stateQ     <= stateD;
      cntQ       <= cntD;
      respValidQ <= respValidD;
      respErrorQ <= respErrorD;
      respRdataQ <= respRdataD;
      ramAddrQ   <= ramAddrD;
      ramDataInQ <= ramDataInD;
      ramWeQ     <= ramWeD;
    end
  end

  // Request capture on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      writeQ    <= 1'b0;
      sizeQ     <= 2'b00;
      unsignedQ <= 1'b0;
      addrQ     <= '0;
      wdataQ    <= '0;
    end else if (accept) begin
      writeQ    <= bus.req_write;
      sizeQ     <= bus.req_size;
      unsignedQ <= bus.req_unsigned;
      addrQ     <= bus.req_addr;
      wdataQ    <= bus.req_wdata[15:0];
    end
  end

  // Next state plus the output values to be held during that state
  always_comb begin
    stateD     = stateQ;
    cntD       = cntQ;
    respValidD = 1'b0;
    respErrorD = 1'b0;
    respRdataD = '0;
    ramAddrD   = '0;
    ramDataInD = '0;
    ramWeD     = 1'b0;
    case (stateQ)
      IDLE: begin
        if (bus.req_valid) begin
          if (illegal) begin
            stateD     = RESP;
            respValidD = 1'b1;
            respErrorD = 1'b1;
          end else if (!bus.req_write || (bus.req_size != 2'b10)) begin
            stateD   = READ;
            cntD     = '0;
            ramAddrD = {bus.req_addr[31:2], 2'b00};
          end else begin
            stateD     = WRITE;
            ramAddrD   = {bus.req_addr[31:2], 2'b00};
            ramDataInD = bus.req_wdata;
            ramWeD     = 1'b1;
          end
        end
      end
      READ: begin
        ramAddrD = {addrQ[31:2], 2'b00};
        if (cntQ == CntW'(RAM_LATENCY)) begin
          if (writeQ) begin
            stateD     = WRITE;
            ramDataInD = mergeStore(bus.ram_data_out, wdataQ, sizeQ, addrQ[1:0]);
            ramWeD     = 1'b1;
          end else begin
            stateD     = RESP;
            ramAddrD   = '0;
            respValidD = 1'b1;
            respRdataD = extractLoad(bus.ram_data_out, sizeQ, addrQ[1:0], unsignedQ);
          end
        end else begin
          cntD = CntW'(cntQ + CntW'(1));
        end
      end
      WRITE: begin
        stateD     = RESP;
        respValidD = 1'b1;
      end
      RESP: begin
        stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  // Ready and write strobe are gated so nothing leaks out while rst is high
  assign bus.req_ready        = (stateQ == IDLE) && !rst;
  assign bus.ram_write_enable = ramWeQ && !rst;
  assign bus.ram_address      = ramAddrQ;
  assign bus.ram_data_in      = ramDataInQ;
  assign bus.resp_valid       = respValidQ;
  assign bus.resp_rdata       = respRdataQ;
  assign bus.resp_error       = respErrorQ;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a one-cycle-latency RAM model.
module tb_mem_access_unit;

  localparam int unsigned Lat = 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } expT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nAssert = 0;
  int   nFail = 0;

  expT  expQ[$];
  expT  e;

  int          writeCount = 0;
  logic [31:0] lastWAddr = '0;
  logic [31:0] lastWData = '0;
  int          lastWCyc = 0;

  logic [31:0] mem [0:15];
  logic [3:0]  rdIdxQ = '0;

  mem_access_unit_if bus();

  mem_access_unit #(.RAM_LATENCY(Lat)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RAM model: registered read address gives one cycle of latency
  always @(posedge clk) begin
    if (bus.ram_write_enable === 1'b1) mem[4'(bus.ram_address >> 2)] <= bus.ram_data_in;
    rdIdxQ <= 4'(bus.ram_address >> 2);
  end
  assign bus.ram_data_out = mem[rdIdxQ];

  // Response monitor: pops the scoreboard on each resp_valid pulse
  initial forever begin
    @(negedge clk);
    if (bus.ram_write_enable === 1'b1) begin
      writeCount++;
      lastWAddr = bus.ram_address;
      lastWData = bus.ram_data_in;
      lastWCyc  = cyc;
    end
    if (bus.resp_valid === 1'b1) begin
      nAssert++;
      if (expQ.size() == 0) begin
        nFail++;
        $display("FAIL unexpected_resp: resp_valid at cycle %0d with nothing outstanding", cyc);
      end else begin
        e = expQ.pop_front();
        if (cyc !== e.cyc) begin
          nFail++;
          $display("FAIL resp_cycle: got %0d expected %0d", cyc, e.cyc);
        end
        nAssert++;
        if (bus.resp_error !== e.err) begin
          nFail++;
          $display("FAIL resp_error: got %b expected %b", bus.resp_error, e.err);
        end
        nAssert++;
        if (bus.resp_rdata !== e.rdata) begin
          nFail++;
          $display("FAIL resp_rdata: got %h expected %h", bus.resp_rdata, e.rdata);
        end
      end
    end else begin
      nAssert++;
      if (bus.resp_rdata !== 32'd0 || bus.resp_error !== 1'b0) begin
        nFail++;
        $display("FAIL idle_resp: rdata %h error %b expected 0 0", bus.resp_rdata, bus.resp_error);
      end
    end
  end

  // Drive one request (called at a negedge), queue its expectation, wait for drain
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic expErr, input logic [31:0] expData,
                       input int lat, output int acc);
    int  w;
    expT x;
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    nAssert++;
    if (bus.req_ready !== 1'b1) begin
      nFail++;
      $display("FAIL ready_timeout: req_ready %b expected 1", bus.req_ready);
    end
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    acc     = cyc;
    x.err   = expErr;
    x.rdata = expData;
    x.cyc   = cyc + lat;
    expQ.push_back(x);
    @(negedge clk);
    bus.req_valid = 1'b0;
    w = 0;
    while (expQ.size() != 0 && w < 30) begin
      @(negedge clk);
      w++;
    end
    nAssert++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("FAIL resp_timeout: %0d responses outstanding expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic checkOutputsZero(input string tag);
    nAssert++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'd0 ||
        bus.resp_error !== 1'b0 || bus.ram_address !== 32'd0 || bus.ram_data_in !== 32'd0 ||
        bus.ram_write_enable !== 1'b0) begin
      nFail++;
      $display("FAIL %s: ready %b rv %b rd %h re %b ra %h rdi %h we %b expected all 0", tag,
               bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_error,
               bus.ram_address, bus.ram_data_in, bus.ram_write_enable);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutputsZero("reset_outputs");
    rst = 1'b0;
    #1;
    nAssert++;
    if (bus.req_ready !== 1'b1) begin
      nFail++;
      $display("FAIL ready_after_reset: got %b expected 1", bus.req_ready);
    end
    @(negedge clk);
  endtask

  task automatic checkWrite(input string tag, input int expCyc,
                            input logic [31:0] expAddr, input logic [31:0] expData);
    nAssert++;
    if (lastWCyc !== expCyc || lastWAddr !== expAddr || lastWData !== expData) begin
      nFail++;
      $display("FAIL %s: write cyc %0d addr %h data %h expected cyc %0d addr %h data %h",
               tag, lastWCyc, lastWAddr, lastWData, expCyc, expAddr, expData);
    end
  endtask

  task automatic test_word();
    int acc;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, acc);
    checkWrite("sw_write", acc + 1, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, Lat + 2, acc);
  endtask

  task automatic test_byte();
    int acc;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'h0, 2, acc);
    issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000AA, 1'b0, 32'h0, Lat + 3, acc);
    checkWrite("sb_merge", acc + Lat + 2, 32'h10, 32'hAA223344);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFFFFAA, Lat + 2, acc);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'h000000AA, Lat + 2, acc);
    issue(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, 32'h00000044, Lat + 2, acc);
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, 32'h00000033, Lat + 2, acc);
  endtask

  task automatic test_half();
    int acc;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h80017FFF, 1'b0, 32'h0, 2, acc);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFF8001, Lat + 2, acc);
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 32'h00008001, Lat + 2, acc);
    issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0, 32'h00007FFF, Lat + 2, acc);
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, 1'b0, 32'h0, Lat + 3, acc);
    checkWrite("sh_merge", acc + Lat + 2, 32'h10, 32'h12347FFF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h12347FFF, Lat + 2, acc);
  endtask

  task automatic test_error();
    int acc;
    int wc;
    wc = writeCount;
    issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b1, 32'h0, 1, acc);
    issue(1'b1, 2'b01, 1'b0, 32'h11, 32'h5555, 1'b1, 32'h0, 1, acc);
    issue(1'b1, 2'b11, 1'b0, 32'h10, 32'h77, 1'b1, 32'h0, 1, acc);
    issue(1'b0, 2'b11, 1'b1, 32'h14, 32'h0, 1'b1, 32'h0, 1, acc);
    nAssert++;
    if (writeCount !== wc) begin
      nFail++;
      $display("FAIL error_no_write: %0d writes expected %0d", writeCount, wc);
    end
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h12347FFF, Lat + 2, acc);
  endtask

  task automatic test_back_to_back();
    int acc;
    issue(1'b1, 2'b10, 1'b0, 32'h18, 32'hCAFEF00D, 1'b0, 32'h0, 2, acc);
    issue(1'b1, 2'b00, 1'b0, 32'h18, 32'h00000011, 1'b0, 32'h0, Lat + 3, acc);
    issue(1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 1'b0, 32'hCAFEF011, Lat + 2, acc);
  endtask

  task automatic test_reset_mid();
    int acc;
    int wc;
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h55667788, 1'b0, 32'h0, 2, acc);
    wc = writeCount;
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b1;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h21;
    bus.req_wdata    = 32'h99;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutputsZero("mid_reset_1");
    @(negedge clk);
    checkOutputsZero("mid_reset_2");
    rst = 1'b0;
    #1;
    nAssert++;
    if (bus.req_ready !== 1'b1) begin
      nFail++;
      $display("FAIL ready_after_mid_reset: got %b expected 1", bus.req_ready);
    end
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h55667788, Lat + 2, acc);
    nAssert++;
    if (writeCount !== wc) begin
      nFail++;
      $display("FAIL mid_reset_no_write: %0d writes expected %0d", writeCount, wc);
    end
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_error();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
